// File: rtl/core_pkg.sv
// Shared core types: forwarding select encodings, hazard FSM states and default widths.
package core_pkg;

   localparam int DEF_REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      HZ_RUN       = 2'b00,
      HZ_LU_STALL  = 2'b01,
      HZ_DMEM_WAIT = 2'b10
   } hz_state_e;

endpackage

// File: rtl/fwd_select.sv
// Single-port forwarding comparator: picks the youngest in-flight producer of one source register.
module fwd_select
   import core_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] i_rs_addr,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
   input  logic                  i_reg_we_mem,
   input  logic                  i_reg_we_wb,
   output fwd_sel_e              o_sel
);

   logic w_rs_nonzero;

   assign w_rs_nonzero = |i_rs_addr;

   // x0 is hard-wired to zero, so it never takes a forwarded value.
   always_comb begin
      o_sel = FWD_RF;
      if (i_reg_we_mem && w_rs_nonzero && (i_rd_addr_mem == i_rs_addr)) begin
         o_sel = FWD_MEM;
      end else if (i_reg_we_wb && w_rs_nonzero && (i_rd_addr_wb == i_rs_addr)) begin
         o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the five-stage core: stalls, flushes, forwarding selects.
// Define HAZARD_PERF_EN to add the saturating stall/flush cycle counters and their ports.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int NUM_RS     = 2,
   parameter int LOAD_LAT   = 1
`ifdef HAZARD_PERF_EN
   ,
   parameter int CNT_W      = 32
`endif
) (
   input  logic                         i_clk,
   input  logic                         i_arst,
   input  logic [NUM_RS*REG_ADDR_W-1:0] i_rs_addr_dec,
   input  logic [NUM_RS*REG_ADDR_W-1:0] i_rs_addr_exec,
   input  logic [REG_ADDR_W-1:0]        i_rd_addr_exec,
   input  logic [REG_ADDR_W-1:0]        i_rd_addr_mem,
   input  logic [REG_ADDR_W-1:0]        i_rd_addr_wb,
   input  logic                         i_reg_we_mem,
   input  logic                         i_reg_we_wb,
   input  logic                         i_load_instr_exec,
   input  logic                         i_pc_src_exec,
   input  logic                         i_imem_ready,
   input  logic                         i_dmem_ready,
   output logic                         o_stall_fetch,
   output logic                         o_stall_dec,
   output logic                         o_stall_exec,
   output logic                         o_stall_mem,
   output logic                         o_flush_dec,
   output logic                         o_flush_exec,
`ifdef HAZARD_PERF_EN
   output logic [CNT_W-1:0]             o_stall_cycles,
   output logic [CNT_W-1:0]             o_flush_cycles,
`endif
   output logic [NUM_RS*2-1:0]          o_forward_rs
);

   hz_state_e  r_state;
   hz_state_e  r_saved_state;
   logic [2:0] r_lu_cnt;

   hz_state_e  w_eff_state;
   hz_state_e  w_next_state;
   hz_state_e  w_next_saved;
   logic [2:0] w_next_cnt;
   logic       w_load_use;
   fwd_sel_e   w_fwd [NUM_RS];

   for (genvar k = 0; k < NUM_RS; k++) begin : g_fwd
      fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
         .i_rs_addr     (i_rs_addr_exec[k*REG_ADDR_W +: REG_ADDR_W]),
         .i_rd_addr_mem (i_rd_addr_mem),
         .i_rd_addr_wb  (i_rd_addr_wb),
         .i_reg_we_mem  (i_reg_we_mem),
         .i_reg_we_wb   (i_reg_we_wb),
         .o_sel         (w_fwd[k])
      );
      assign o_forward_rs[k*2 +: 2] = i_arst ? FWD_RF : w_fwd[k];
   end

   always_comb begin
      w_load_use = 1'b0;
      for (int k = 0; k < NUM_RS; k++) begin
         if (i_rs_addr_dec[k*REG_ADDR_W +: REG_ADDR_W] == i_rd_addr_exec) begin
            w_load_use = 1'b1;
         end
      end
      w_load_use = w_load_use && i_load_instr_exec && (|i_rd_addr_exec);
   end

   // A frozen pipe resumes as if the wait never happened, so while waiting
   // the saved state (and untouched counter) drives the decision.
   assign w_eff_state = (r_state == HZ_DMEM_WAIT) ? r_saved_state : r_state;

   always_comb begin
      w_next_state  = w_eff_state;
      w_next_saved  = r_saved_state;
      w_next_cnt    = r_lu_cnt;
      o_stall_fetch = 1'b0;
      o_stall_dec   = 1'b0;
      o_stall_exec  = 1'b0;
      o_stall_mem   = 1'b0;
      o_flush_dec   = 1'b0;
      o_flush_exec  = 1'b0;
      if (i_arst) begin
         o_flush_dec  = 1'b1;
         o_flush_exec = 1'b1;
      end else if (!i_dmem_ready) begin
         o_stall_fetch = 1'b1;
         o_stall_dec   = 1'b1;
         o_stall_exec  = 1'b1;
         o_stall_mem   = 1'b1;
         w_next_state  = HZ_DMEM_WAIT;
         w_next_saved  = w_eff_state;
      end else if (i_pc_src_exec) begin
         o_flush_dec  = 1'b1;
         o_flush_exec = 1'b1;
         w_next_state = HZ_RUN;
         w_next_cnt   = 3'd0;
      end else if (w_eff_state == HZ_LU_STALL) begin
         o_stall_fetch = 1'b1;
         o_stall_dec   = 1'b1;
         o_flush_exec  = 1'b1;
         w_next_cnt    = r_lu_cnt - 3'd1;
         w_next_state  = (r_lu_cnt == 3'd1) ? HZ_RUN : HZ_LU_STALL;
      end else if (w_load_use) begin
         o_stall_fetch = 1'b1;
         o_stall_dec   = 1'b1;
         o_flush_exec  = 1'b1;
         if (LOAD_LAT > 1) begin
            w_next_state = HZ_LU_STALL;
            w_next_cnt   = 3'(LOAD_LAT - 1);
         end
      end else if (!i_imem_ready) begin
         o_stall_fetch = 1'b1;
         o_flush_dec   = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_state       <= HZ_RUN;
         r_saved_state <= HZ_RUN;
         r_lu_cnt      <= 3'd0;
      end else begin
         r_state       <= w_next_state;
         r_saved_state <= w_next_saved;
         r_lu_cnt      <= w_next_cnt;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_cycles;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_stall_cycles <= '0;
         r_flush_cycles <= '0;
      end else begin
         if (o_stall_dec && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         if (o_flush_exec && !(&r_flush_cycles)) begin
            r_flush_cycles <= r_flush_cycles + CNT_W'(1);
         end
      end
   end

   assign o_stall_cycles = r_stall_cycles;
   assign o_flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_ctrl;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_RS     = 2;
   localparam int LOAD_LAT   = 3;
`ifdef HAZARD_PERF_EN
   localparam int CNT_W      = 4;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  arst;
   logic [REG_ADDR_W-1:0] rsDec [NUM_RS];
   logic [REG_ADDR_W-1:0] rsExec [NUM_RS];
   logic [REG_ADDR_W-1:0] rdExec, rdMem, rdWb;
   logic                  weMem, weWb, loadExec, pcSrc, imemRdy, dmemRdy;

   logic [NUM_RS*REG_ADDR_W-1:0] rsDecBus, rsExecBus;
   logic                         stallF, stallD, stallE, stallM, flushD, flushE;
   logic [NUM_RS*2-1:0]          fwdBus;
   logic [5:0]                   ctrlBus;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0]             stallCnt, flushCnt;
`endif

   always_comb begin
      rsDecBus  = '0;
      rsExecBus = '0;
      for (int k = 0; k < NUM_RS; k++) begin
         rsDecBus[k*REG_ADDR_W +: REG_ADDR_W]  = rsDec[k];
         rsExecBus[k*REG_ADDR_W +: REG_ADDR_W] = rsExec[k];
      end
   end

   assign ctrlBus = {stallF, stallD, stallE, stallM, flushD, flushE};

   hazard_ctrl #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_RS     (NUM_RS),
      .LOAD_LAT   (LOAD_LAT)
`ifdef HAZARD_PERF_EN
      ,
      .CNT_W      (CNT_W)
`endif
   ) dut (
      .i_clk             (clk),
      .i_arst            (arst),
      .i_rs_addr_dec     (rsDecBus),
      .i_rs_addr_exec    (rsExecBus),
      .i_rd_addr_exec    (rdExec),
      .i_rd_addr_mem     (rdMem),
      .i_rd_addr_wb      (rdWb),
      .i_reg_we_mem      (weMem),
      .i_reg_we_wb       (weWb),
      .i_load_instr_exec (loadExec),
      .i_pc_src_exec     (pcSrc),
      .i_imem_ready      (imemRdy),
      .i_dmem_ready      (dmemRdy),
      .o_stall_fetch     (stallF),
      .o_stall_dec       (stallD),
      .o_stall_exec      (stallE),
      .o_stall_mem       (stallM),
      .o_flush_dec       (flushD),
      .o_flush_exec      (flushE),
`ifdef HAZARD_PERF_EN
      .o_stall_cycles    (stallCnt),
      .o_flush_cycles    (flushCnt),
`endif
      .o_forward_rs      (fwdBus)
   );

   int assertions = 0;
   int failures   = 0;
   int mBubbles   = 0;
   int mStallCnt  = 0;
   int mFlushCnt  = 0;

   // Every comparison funnels through here so the totals stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertions++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic setIdle();
      arst     = 1'b0;
      rdExec   = '0;
      rdMem    = '0;
      rdWb     = '0;
      weMem    = 1'b0;
      weWb     = 1'b0;
      loadExec = 1'b0;
      pcSrc    = 1'b0;
      imemRdy  = 1'b1;
      dmemRdy  = 1'b1;
      for (int k = 0; k < NUM_RS; k++) begin
         rsDec[k]  = '0;
         rsExec[k] = '0;
      end
   endtask

   // Model: remaining load-use bubbles as a plain integer, applied with the priority rules.
   task automatic applyStimulus();
      logic [5:0]        expCtrl;
      logic [NUM_RS*2-1:0] expFwd;
      int                nextBubbles;
      bit                loadUse;
      #1;
      nextBubbles = mBubbles;
      loadUse     = 1'b0;
      for (int k = 0; k < NUM_RS; k++) begin
         if (loadExec && rdExec != 0 && rsDec[k] == rdExec) loadUse = 1'b1;
      end
      if (arst) begin
         expCtrl     = 6'b000011;
         nextBubbles = 0;
      end else if (!dmemRdy) begin
         expCtrl = 6'b111100;
      end else if (pcSrc) begin
         expCtrl     = 6'b000011;
         nextBubbles = 0;
      end else if (mBubbles > 0) begin
         expCtrl     = 6'b110001;
         nextBubbles = mBubbles - 1;
      end else if (loadUse) begin
         expCtrl     = 6'b110001;
         nextBubbles = LOAD_LAT - 1;
      end else if (!imemRdy) begin
         expCtrl = 6'b100010;
      end else begin
         expCtrl = 6'b000000;
      end
      expFwd = '0;
      for (int k = 0; k < NUM_RS; k++) begin
         if (!arst && weMem && rdMem != 0 && rdMem == rsExec[k]) expFwd[k*2 +: 2] = 2'b10;
         else if (!arst && weWb && rdWb != 0 && rdWb == rsExec[k]) expFwd[k*2 +: 2] = 2'b01;
      end
      checkOutput("ctrl", 32'(ctrlBus), 32'(expCtrl));
      checkOutput("fwd", 32'(fwdBus), 32'(expFwd));
`ifdef HAZARD_PERF_EN
      checkOutput("stallCnt", 32'(stallCnt), mStallCnt);
      checkOutput("flushCnt", 32'(flushCnt), mFlushCnt);
      if (arst) begin
         mStallCnt = 0;
         mFlushCnt = 0;
      end else begin
         if (expCtrl[4] && mStallCnt < (1 << CNT_W) - 1) mStallCnt++;
         if (expCtrl[0] && mFlushCnt < (1 << CNT_W) - 1) mFlushCnt++;
      end
`endif
      mBubbles = nextBubbles;
      @(negedge clk);
   endtask

   task automatic runCycle(input string tag, input logic [5:0] exp);
      #1;
      checkOutput(tag, 32'(ctrlBus), 32'(exp));
      applyStimulus();
   endtask

   initial begin
      setIdle();
      arst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] reset outputs");
      runCycle("reset", 6'b000011);

      $display("[TB] forwarding");
      setIdle();
      rsExec[0] = 5; rdMem = 5; weMem = 1'b1; rdWb = 5; weWb = 1'b1;
      #1 checkOutput("fwdMemWins", 32'(fwdBus[1:0]), 32'h2);
      applyStimulus();
      weMem = 1'b0;
      #1 checkOutput("fwdWb", 32'(fwdBus[1:0]), 32'h1);
      applyStimulus();
      setIdle();
      rdMem = 0; rsExec[1] = 0; weMem = 1'b1;
      #1 checkOutput("fwdX0", 32'(fwdBus[3:2]), 32'h0);
      applyStimulus();

      $display("[TB] load-use");
      setIdle();
      loadExec = 1'b1; rdExec = 7; rsDec[1] = 7;
      runCycle("lu1", 6'b110001);
      loadExec = 1'b0;
      runCycle("lu2", 6'b110001);
      runCycle("lu3", 6'b110001);
      runCycle("luDone", 6'b000000);

      $display("[TB] branch during load-use");
      loadExec = 1'b1;
      runCycle("brLu1", 6'b110001);
      loadExec = 1'b0; pcSrc = 1'b1;
      runCycle("brFlush", 6'b000011);
      pcSrc = 1'b0;
      runCycle("brRun1", 6'b000000);
      runCycle("brRun2", 6'b000000);

      $display("[TB] dmem wait during load-use");
      loadExec = 1'b1;
      runCycle("dmLu1", 6'b110001);
      loadExec = 1'b0; dmemRdy = 1'b0;
      for (int i = 0; i < 4; i++) runCycle("dmFreeze", 6'b111100);
      dmemRdy = 1'b1;
      runCycle("dmLu2", 6'b110001);
      runCycle("dmLu3", 6'b110001);
      runCycle("dmDone", 6'b000000);

      $display("[TB] reset during dmem wait");
      loadExec = 1'b1;
      runCycle("rmLu1", 6'b110001);
      loadExec = 1'b0; dmemRdy = 1'b0;
      runCycle("rmFreeze", 6'b111100);
      arst = 1'b1;
      runCycle("rmReset", 6'b000011);
      arst = 1'b0; dmemRdy = 1'b1;
`ifdef HAZARD_PERF_EN
      #1 checkOutput("cntAfterRst", 32'(stallCnt), 32'h0);
`endif
      runCycle("rmRun", 6'b000000);

`ifdef HAZARD_PERF_EN
      $display("[TB] counter saturation");
      dmemRdy = 1'b0;
      repeat (20) applyStimulus();
      dmemRdy = 1'b1;
      #1 checkOutput("stallSat", 32'(stallCnt), 32'hF);
      applyStimulus();
`endif

      $display("[TB] randomized traffic");
      for (int n = 0; n < 3000; n++) begin
         arst     = ($urandom_range(0, 99) < 2);
         rdExec   = REG_ADDR_W'($urandom_range(0, 3));
         rdMem    = REG_ADDR_W'($urandom_range(0, 3));
         rdWb     = REG_ADDR_W'($urandom_range(0, 3));
         weMem    = 1'($urandom_range(0, 1));
         weWb     = 1'($urandom_range(0, 1));
         loadExec = ($urandom_range(0, 99) < 40);
         pcSrc    = ($urandom_range(0, 99) < 10);
         imemRdy  = ($urandom_range(0, 99) < 80);
         dmemRdy  = ($urandom_range(0, 99) < 85);
         for (int k = 0; k < NUM_RS; k++) begin
            rsDec[k]  = REG_ADDR_W'($urandom_range(0, 3));
            rsExec[k] = REG_ADDR_W'($urandom_range(0, 3));
         end
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
